// File: rtl/color_classifier.sv
// Color classifier: normalizes red/blue/green counts to percent-of-clear and picks a color code.
// Optional COLOR_CLASS_DEBOUNCE_EN: color changes only after DEBOUNCE_FRAMES identical candidates.
module color_classifier #(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int BLUE_LO         = 61,
   parameter int BLUE_HI         = 84,
   parameter int GREEN_LO        = 57,
   parameter int GREEN_HI        = 80,
   parameter int RED_LO          = 84,
   parameter int RED_HI          = 105
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  filter_in,
   input  logic [31:0] count_in,
   input  logic        count_valid,
   output logic [2:0]  color,
   output logic        color_valid,
   output logic [7:0]  red_pct,
   output logic [7:0]  blue_pct,
   output logic [7:0]  green_pct,
   output logic        busy,
   output logic        frame_drop
);

   typedef enum logic [2:0] {COLLECT, DIV_R, DIV_B, DIV_G, CLASSIFY} state_t;

   localparam logic [1:0] F_RED   = 2'b00;
   localparam logic [1:0] F_BLUE  = 2'b01;
   localparam logic [1:0] F_GREEN = 2'b11;
   localparam logic [1:0] F_CLEAR = 2'b10;

   localparam logic [7:0] B_LO = 8'(BLUE_LO);
   localparam logic [7:0] B_HI = 8'(BLUE_HI);
   localparam logic [7:0] G_LO = 8'(GREEN_LO);
   localparam logic [7:0] G_HI = 8'(GREEN_HI);
   localparam logic [7:0] R_LO = 8'(RED_LO);
   localparam logic [7:0] R_HI = 8'(RED_HI);

   if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
      $error("DEBOUNCE_FRAMES must be in 1..15");
   end

   state_t      state;
   logic        vld_p0;
   logic [1:0]  filt_p0;
   logic [31:0] cnt_p0;
   logic [31:0] ch_r, ch_b, ch_g, ch_c;
   logic        seen_r, seen_b, seen_g;
   logic [3:0]  step;
   logic [39:0] rem;
   logic [7:0]  quo;
   logic        div_zero, div_sat;

   logic [31:0] div_chan;
   logic [39:0] dividend, clr_w, trial, rem_nx;
   logic [2:0]  bit_idx;
   logic        take;
   logic [7:0]  quo_nx, pct_res;
   logic [2:0]  cand;

   function automatic logic [7:0] pct_result(input logic zero, input logic sat,
                                             input logic [7:0] q);
      if (zero)
         return 8'd0;
      else if (sat)
         return 8'd255;
      else
         return q;
   endfunction

   // Strict windows, blue has priority over green, green over red.
   function automatic logic [2:0] classify(input logic [7:0] r, input logic [7:0] b,
                                           input logic [7:0] g);
      if (b > B_LO && b < B_HI)
         return 3'b001;
      else if (g > G_LO && g < G_HI)
         return 3'b010;
      else if (r > R_LO && r < R_HI)
         return 3'b100;
      else
         return 3'b000;
   endfunction

   always_comb begin
      case (state)
         DIV_B:   div_chan = ch_b;
         DIV_G:   div_chan = ch_g;
         default: div_chan = ch_r;
      endcase
   end

   assign dividend = {8'd0, div_chan} * 40'd100;
   assign clr_w    = {8'd0, ch_c};
   assign bit_idx  = 3'(4'd8 - step);
   assign trial    = clr_w << bit_idx;
   assign take     = (rem >= trial);
   assign rem_nx   = take ? (rem - trial) : rem;
   assign quo_nx   = quo | (take ? (8'd1 << bit_idx) : 8'd0);
   assign pct_res  = pct_result(div_zero, div_sat, quo_nx);
   assign cand     = classify(red_pct, blue_pct, green_pct);

`ifdef COLOR_CLASS_DEBOUNCE_EN
   localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

   logic [2:0] prev_cand;
   logic [3:0] stable_cnt, stable_nx;

   always_comb begin
      stable_nx = 4'd1;
      if (cand == prev_cand)
         stable_nx = (stable_cnt >= DEB_N) ? DEB_N : stable_cnt + 4'd1;
   end
`endif

   // Stage p0: input strobe register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         filt_p0 <= 2'b00;
         cnt_p0  <= 32'd0;
      end else begin
         vld_p0  <= count_valid;
         filt_p0 <= filter_in;
         cnt_p0  <= count_in;
      end
   end

   // Stage p1: frame collection, sequential division and classification
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= COLLECT;
         ch_r        <= 32'd0;
         ch_b        <= 32'd0;
         ch_g        <= 32'd0;
         ch_c        <= 32'd0;
         seen_r      <= 1'b0;
         seen_b      <= 1'b0;
         seen_g      <= 1'b0;
         step        <= 4'd0;
         rem         <= 40'd0;
         quo         <= 8'd0;
         div_zero    <= 1'b0;
         div_sat     <= 1'b0;
         color       <= 3'b000;
         color_valid <= 1'b0;
         red_pct     <= 8'd0;
         blue_pct    <= 8'd0;
         green_pct   <= 8'd0;
         busy        <= 1'b0;
         frame_drop  <= 1'b0;
`ifdef COLOR_CLASS_DEBOUNCE_EN
         prev_cand   <= 3'b000;
         stable_cnt  <= 4'd0;
`endif
      end else begin
         color_valid <= 1'b0;
         frame_drop  <= 1'b0;
         if (state != COLLECT && vld_p0 && filt_p0 == F_CLEAR)
            frame_drop <= 1'b1;

         case (state)
            COLLECT: begin
               if (vld_p0) begin
                  case (filt_p0)
                     F_RED: begin
                        ch_r   <= cnt_p0;
                        seen_r <= 1'b1;
                     end
                     F_BLUE: begin
                        ch_b   <= cnt_p0;
                        seen_b <= 1'b1;
                     end
                     F_GREEN: begin
                        ch_g   <= cnt_p0;
                        seen_g <= 1'b1;
                     end
                     default: begin
                        seen_r <= 1'b0;
                        seen_b <= 1'b0;
                        seen_g <= 1'b0;
                        if (seen_r && seen_b && seen_g) begin
                           ch_c  <= cnt_p0;
                           step  <= 4'd0;
                           busy  <= 1'b1;
                           state <= DIV_R;
                        end else begin
                           frame_drop <= 1'b1;
                        end
                     end
                  endcase
               end
            end

            DIV_R, DIV_B, DIV_G: begin
               if (step == 4'd0) begin
                  rem      <= dividend;
                  quo      <= 8'd0;
                  div_zero <= (ch_c == 32'd0);
                  div_sat  <= (ch_c != 32'd0) && (dividend >= (clr_w << 8));
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
               end

               if (step == 4'd8) begin
                  step <= 4'd0;
                  case (state)
                     DIV_R: begin
                        red_pct <= pct_res;
                        state   <= DIV_B;
                     end
                     DIV_B: begin
                        blue_pct <= pct_res;
                        state    <= DIV_G;
                     end
                     default: begin
                        green_pct <= pct_res;
                        state     <= CLASSIFY;
                     end
                  endcase
               end else begin
                  step <= step + 4'd1;
               end
            end

            CLASSIFY: begin
`ifdef COLOR_CLASS_DEBOUNCE_EN
               prev_cand  <= cand;
               stable_cnt <= stable_nx;
               if (stable_nx == DEB_N)
                  color <= cand;
`else
               color <= cand;
`endif
               color_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= COLLECT;
            end

            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: doc/color_classifier.md
Name: color_classifier

Overview:
- Downstream consumer of the color sensor front end.
- Takes the per-filter frequency counts (red, blue, green, clear) as each integration window closes.
- Normalizes red, blue and green to percent-of-clear using a sequential divider, then classifies against fixed windows.
- Debounces the decision across frames and presents a stable 3-bit color code to the rover control logic.

Parameters:
- DEBOUNCE_FRAMES, 3, consecutive identical candidates required before color output changes (1..15).
- BLUE_LO, 61, blue window lower bound, exclusive, in percent.
- BLUE_HI, 84, blue window upper bound, exclusive.
- GREEN_LO, 57, green window lower bound, exclusive.
- GREEN_HI, 80, green window upper bound, exclusive.
- RED_LO, 84, red window lower bound, exclusive.
- RED_HI, 105, red window upper bound, exclusive.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- filter_in  in  2  channel of count_in: 00 red, 01 blue, 11 green, 10 clear.
- count_in  in  32  edge count for the completed window.
- count_valid  in  1  one-cycle strobe; count_in/filter_in are valid.
- color  out  3  stable color: 001 blue, 010 green, 100 red, 000 none.
- color_valid  out  1  one-cycle pulse per processed frame.
- red_pct  out  8  last normalized red, saturating at 255.
- blue_pct  out  8  last normalized blue.
- green_pct  out  8  last normalized green.
- busy  out  1  high outside COLLECT.
- frame_drop  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (async, any state): outputs all 0; state COLLECT; channel registers, received flags, candidate and debounce counter cleared.
- COLLECT:
  - A count_valid with R/B/G code stores count_in and sets that channel's received flag.
  - A repeated channel overwrites the stored value.
  - A count_valid with clear code:
    - If all three flags are set: store clear, go to DIV_R, clear the flags.
    - Otherwise: pulse frame_drop, clear the flags, stay in COLLECT.
- DIV_R, DIV_B, DIV_G: 9 cycles each.
  - Cycle 0 (load): dividend = chan*100 in 40-bit arithmetic.
    - If clear == 0, pct = 0 and the remaining 8 cycles idle.
    - Else if dividend >= clear<<8, pct = 255 (saturate).
  - Cycles 1-8: restoring division, i = 7 down to 0. If rem >= clear<<i, subtract and set q[i].
  - The pct register is updated at the end of the channel's 9th cycle.
  - Order is R, then B, then G.
- CLASSIFY (1 cycle): candidate is chosen by priority.
  - BLUE_LO < blue_pct < BLUE_HI gives 001.
  - Else GREEN_LO < green_pct < GREEN_HI gives 010.
  - Else RED_LO < red_pct < RED_HI gives 100.
  - Else 000.
  - Comparisons are unsigned and strict.
- Debounce:
  - If candidate equals the previous candidate, stable_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stable_cnt = 1.
  - When stable_cnt reaches DEBOUNCE_FRAMES, color <= candidate; otherwise color holds.
  - color_valid pulses on the cycle after CLASSIFY; state returns to COLLECT in the same cycle.
- Latency: clear strobe sampled at edge N gives color_valid high in the cycle after edge N+29. busy is high from edge N+1 through the CLASSIFY cycle.
- count_valid while busy:
  - Ignored; no storage.
  - frame_drop pulses if the code is clear; otherwise no pulse.
  - Flags remain cleared, so the next frame must be complete.
- *_pct outputs update only at frame completion and hold otherwise.

Optional Feature:
- Macro COLOR_CLASS_DEBOUNCE_EN.
- Defined: debounce as described.
- Undefined: stable_cnt logic removed; color <= candidate on every processed frame; DEBOUNCE_FRAMES is unused.

Test Plan:
- Three frames of R=900, B=700, G=600, C=1000 -> pct 90/70/60. color stays 000 after frames 1-2, becomes 001 after frame 3. color_valid fires 29 clocks after each clear strobe.
- R=950, B=500, G=400, C=1000, three frames -> pct 95/50/40, color 100. Then one frame with B=700 -> color stays 100 (debounce).
- R=5000, B=0, G=0, C=1000 -> red_pct 255, no window hit, candidate 000. C=0 with any R/B/G -> all pct 0.
- Red, green, clear without blue -> frame_drop pulse, no color_valid, busy stays 0. Then a full frame processes normally.
- Assert rst during DIV_B -> all outputs 0 immediately. A subsequent full frame yields color_valid after 29 clocks. Second clear strobe while busy -> frame_drop pulse, no effect on the in-flight result.
- Build without COLOR_CLASS_DEBOUNCE_EN: single frame 900/700/600/1000 -> color 001 on the first color_valid.
